// File: rtl/wt_wbuf_coalesce.sv
// Store write buffer for the write-through D-cache: FIFO of word-aligned stores with
// youngest-entry coalescing and load hazard check. Optional forwarding under `WBUF_FWD_EN.
module wt_wbuf_coalesce #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned BE_W  = DATA_W / 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_data_i,
  input  logic [BE_W-1:0]   req_be_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic [BE_W-1:0]   mem_be_o,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [BE_W-1:0]   ld_be_i,
  output logic              ld_hit_o,
  output logic              ld_fwd_valid_o,
  output logic [DATA_W-1:0] ld_fwd_data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              empty_o,
  output logic              full_o
);

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [BE_W-1:0]   r_be   [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic [ADDR_W-1:0] w_req_waddr;
  logic [ADDR_W-1:0] w_ld_waddr;
  logic [DATA_W-1:0] w_req_mdata;
  logic [PTR_W-1:0]  w_young;
  logic [PTR_W-1:0]  w_head_nxt;
  logic [PTR_W-1:0]  w_tail_nxt;
  logic              w_hit;
  logic              w_push;
  logic              w_pop;
  logic              w_alloc;
  logic              w_coal;
  logic              w_ld_hit;

  assign w_req_waddr = req_addr_i & ~ADDR_W'(BE_W - 1);
  assign w_ld_waddr  = ld_addr_i & ~ADDR_W'(BE_W - 1);

  // Disabled lanes of a freshly allocated entry are stored as zero
  always_comb begin
    w_req_mdata = '0;
    for (int unsigned b = 0; b < BE_W; b++) begin
      if (req_be_i[b]) w_req_mdata[b*8 +: 8] = req_data_i[b*8 +: 8];
    end
  end

  assign w_young    = (r_tail == '0) ? PTR_W'(DEPTH - 1) : r_tail - PTR_W'(1);
  assign w_head_nxt = (r_head == PTR_W'(DEPTH - 1)) ? '0 : r_head + PTR_W'(1);
  assign w_tail_nxt = (r_tail == PTR_W'(DEPTH - 1)) ? '0 : r_tail + PTR_W'(1);

  // With count>=2 the youngest entry is never the head, so merging cannot race the drain
  assign w_hit   = (r_count >= CNT_W'(2)) && (r_addr[w_young] == w_req_waddr);

  assign empty_o     = (r_count == '0);
  assign full_o      = (r_count == CNT_W'(DEPTH));
  assign count_o     = r_count;
  assign req_ready_o = ~full_o | w_hit;
  assign mem_valid_o = ~empty_o;

  assign w_push  = req_valid_i & req_ready_o;
  assign w_pop   = mem_valid_o & mem_ready_i;
  assign w_alloc = w_push & ~w_hit;
  assign w_coal  = w_push & w_hit;

  assign mem_addr_o = empty_o ? '0 : r_addr[r_head];
  assign mem_data_o = empty_o ? '0 : r_data[r_head];
  assign mem_be_o   = empty_o ? '0 : r_be[r_head];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_be[i]   <= '0;
      end
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= w_head_nxt;
      end
      if (w_alloc) begin
        r_addr[r_tail]  <= w_req_waddr;
        r_data[r_tail]  <= w_req_mdata;
        r_be[r_tail]    <= req_be_i;
        r_valid[r_tail] <= 1'b1;
        r_tail          <= w_tail_nxt;
      end
      if (w_coal) begin
        for (int unsigned b = 0; b < BE_W; b++) begin
          if (req_be_i[b]) r_data[w_young][b*8 +: 8] <= req_data_i[b*8 +: 8];
        end
        r_be[w_young] <= r_be[w_young] | req_be_i;
      end
      r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);
    end
  end

  // Load hazard: any live entry touching a requested byte of the same word
  always_comb begin
    w_ld_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i] == w_ld_waddr) && (|(r_be[i] & ld_be_i))) w_ld_hit = 1'b1;
    end
  end
  assign ld_hit_o = w_ld_hit;

`ifdef WBUF_FWD_EN
  logic              w_fwd_found;
  logic [PTR_W-1:0]  w_fwd_sel;
  logic [DATA_W-1:0] w_fwd_data;
  int unsigned       w_idx;

  // Walk entries oldest to youngest so the last match is the youngest one
  always_comb begin
    w_fwd_found = 1'b0;
    w_fwd_sel   = '0;
    w_idx       = 0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_idx = 32'(r_head) + k;
      if (w_idx >= DEPTH) w_idx = w_idx - DEPTH;
      if ((k < 32'(r_count)) && (r_addr[w_idx] == w_ld_waddr)) begin
        w_fwd_found = 1'b1;
        w_fwd_sel   = PTR_W'(w_idx);
      end
    end
  end

  always_comb begin
    w_fwd_data = '0;
    for (int unsigned b = 0; b < BE_W; b++) begin
      if (ld_be_i[b]) w_fwd_data[b*8 +: 8] = r_data[w_fwd_sel][b*8 +: 8];
    end
  end

  assign ld_fwd_valid_o = w_fwd_found && ((r_be[w_fwd_sel] & ld_be_i) == ld_be_i);
  assign ld_fwd_data_o  = ld_fwd_valid_o ? w_fwd_data : '0;
`else
  assign ld_fwd_valid_o = 1'b0;
  assign ld_fwd_data_o  = '0;
`endif

endmodule

// File: tb/tb_wt_wbuf_coalesce.sv
// Scoreboard bench for wt_wbuf_coalesce (DEPTH=3): expected memory beats are modelled on
// store acceptance and compared as the buffer drains.
module tb_wt_wbuf_coalesce;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_data_i = '0;
  logic [3:0]  req_be_i = '0;
  logic        mem_valid_o;
  logic        mem_ready_i = 1'b0;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [3:0]  mem_be_o;
  logic [31:0] ld_addr_i = '0;
  logic [3:0]  ld_be_i = '0;
  logic        ld_hit_o;
  logic        ld_fwd_valid_o;
  logic [31:0] ld_fwd_data_o;
  logic [1:0]  count_o;
  logic        empty_o;
  logic        full_o;

  int    n_checks = 0;
  int    n_pass = 0;
  beat_t q[$];
  logic  m_fire = 1'b0;
  beat_t m_beat;
  logic  done = 1'b0;

  always #5 clk = ~clk;

  wt_wbuf_coalesce #(.DEPTH(3), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_data_i(req_data_i), .req_be_i(req_be_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_be_o(mem_be_o),
    .ld_addr_i(ld_addr_i), .ld_be_i(ld_be_i), .ld_hit_o(ld_hit_o),
    .ld_fwd_valid_o(ld_fwd_valid_o), .ld_fwd_data_o(ld_fwd_data_o),
    .count_o(count_o), .empty_o(empty_o), .full_o(full_o)
  );

  // Reference model of buffer contents in drain order
  function automatic void model_push(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    beat_t t;
    int n = q.size();
    if (n >= 2 && q[n-1].addr == (a & 32'hFFFF_FFFC)) begin
      t = q[n-1];
      for (int b = 0; b < 4; b++) if (be[b]) begin t.data[b*8 +: 8] = d[b*8 +: 8]; t.be[b] = 1'b1; end
      q[n-1] = t;
    end else begin
      t.addr = a & 32'hFFFF_FFFC;
      t.be   = be;
      t.data = '0;
      for (int b = 0; b < 4; b++) if (be[b]) t.data[b*8 +: 8] = d[b*8 +: 8];
      q.push_back(t);
    end
  endfunction

  // Handshake observed at the negedge completes on the following posedge
  always @(negedge clk) begin
    m_fire = rst_n && mem_valid_o && mem_ready_i;
    m_beat = '{addr: mem_addr_o, data: mem_data_o, be: mem_be_o};
  end

  always @(posedge clk) begin
    if (m_fire) begin
      beat_t e;
      n_checks++;
      if (q.size() == 0) begin
        $display("FAIL beat_unexpected got addr=%h data=%h be=%b with nothing pending", m_beat.addr, m_beat.data, m_beat.be);
      end else begin
        e = q.pop_front();
        if (m_beat !== e)
          $display("FAIL beat got addr=%h data=%h be=%b exp addr=%h data=%h be=%b",
                   m_beat.addr, m_beat.data, m_beat.be, e.addr, e.data, e.be);
        else n_pass++;
      end
    end
  end

  // Enter and leave on posedge+1; holds the request until accepted
  task automatic drive_store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    int cyc = 0;
    req_valid_i = 1'b1; req_addr_i = a; req_be_i = be; req_data_i = d;
    @(negedge clk);
    while (!req_ready_o && cyc < 50) begin @(negedge clk); cyc++; end
    if (!req_ready_o) begin
      n_checks++;
      $display("FAIL store_timeout addr=%h ready got 0 exp 1", a);
    end else model_push(a, be, d);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int cyc = 0;
    mem_ready_i = 1'b1;
    @(negedge clk);
    while (!(q.size() == 0 && empty_o) && cyc < 200) begin @(negedge clk); cyc++; end
    n_checks++;
    if (!(q.size() == 0 && empty_o === 1'b1))
      $display("FAIL drain got empty=%b pending=%0d exp empty=1 pending=0", empty_o, q.size());
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_checks++; if (count_o !== 2'd0 || empty_o !== 1'b1 || full_o !== 1'b0) $display("FAIL rst_status got cnt=%0d e=%b f=%b exp 0/1/0", count_o, empty_o, full_o); else n_pass++;
    n_checks++; if (mem_valid_o !== 1'b0 || mem_addr_o !== 32'h0 || mem_be_o !== 4'h0) $display("FAIL rst_mem got v=%b a=%h be=%b exp 0", mem_valid_o, mem_addr_o, mem_be_o); else n_pass++;
    n_checks++; if (req_ready_o !== 1'b1 || ld_hit_o !== 1'b0 || ld_fwd_valid_o !== 1'b0) $display("FAIL rst_ctl got rdy=%b hit=%b fwd=%b exp 1/0/0", req_ready_o, ld_hit_o, ld_fwd_valid_o); else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    mem_ready_i = 1'b0;
    drive_store(32'h0000_0010, 4'hF, 32'h1111_1111);
    drive_store(32'h0000_0020, 4'hF, 32'h2222_2222);
    n_checks++; if (count_o !== 2'd2 || mem_valid_o !== 1'b1) $display("FAIL pre_rst got cnt=%0d v=%b exp 2/1", count_o, mem_valid_o); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (count_o !== 2'd0 || empty_o !== 1'b1 || mem_valid_o !== 1'b0) $display("FAIL mid_rst got cnt=%0d e=%b v=%b exp 0/1/0", count_o, empty_o, mem_valid_o); else n_pass++;
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_order();
    mem_ready_i = 1'b0;
    drive_store(32'h100, 4'hF, 32'hA000_0100);
    drive_store(32'h104, 4'hF, 32'hA000_0104);
    drive_store(32'h108, 4'hF, 32'hA000_0108);
    req_valid_i = 1'b1; req_addr_i = 32'h10C; req_be_i = 4'hF; req_data_i = 32'hA000_010C;
    @(negedge clk);
    n_checks++; if (full_o !== 1'b1 || count_o !== 2'd3) $display("FAIL full got f=%b cnt=%0d exp 1/3", full_o, count_o); else n_pass++;
    n_checks++; if (req_ready_o !== 1'b0) $display("FAIL full_ready got %b exp 0", req_ready_o); else n_pass++;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    wait_drain();
  endtask

  task automatic test_coalesce();
    mem_ready_i = 1'b0;
    drive_store(32'h200, 4'b0011, 32'h0000_BBAA);
    drive_store(32'h204, 4'b0011, 32'h0000_2211);
    drive_store(32'h206, 4'b1100, 32'hDDCC_0000);
    n_checks++; if (count_o !== 2'd2) $display("FAIL coal_count got %0d exp 2", count_o); else n_pass++;
    wait_drain();
  endtask

  task automatic test_head_protect();
    mem_ready_i = 1'b0;
    drive_store(32'h300, 4'hF, 32'h0000_0001);
    drive_store(32'h300, 4'b0001, 32'h0000_00EE);
    n_checks++; if (count_o !== 2'd2) $display("FAIL head_protect_count got %0d exp 2", count_o); else n_pass++;
    wait_drain();
  endtask

  task automatic test_full_pop();
    mem_ready_i = 1'b0;
    drive_store(32'h500, 4'hF, 32'h5);
    drive_store(32'h504, 4'hF, 32'h6);
    drive_store(32'h508, 4'hF, 32'h7);
    mem_ready_i = 1'b1;
    req_valid_i = 1'b1; req_addr_i = 32'h50C; req_be_i = 4'hF; req_data_i = 32'h8;
    @(negedge clk);
    n_checks++; if (req_ready_o !== 1'b0 || count_o !== 2'd3) $display("FAIL fullpop_c0 got rdy=%b cnt=%0d exp 0/3", req_ready_o, count_o); else n_pass++;
    @(posedge clk); #1;
    mem_ready_i = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready_o !== 1'b1 || count_o !== 2'd2) $display("FAIL fullpop_c1 got rdy=%b cnt=%0d exp 1/2", req_ready_o, count_o); else n_pass++;
    if (req_ready_o) model_push(32'h50C, 4'hF, 32'h8);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(negedge clk);
    n_checks++; if (count_o !== 2'd3) $display("FAIL fullpop_c2 got cnt=%0d exp 3", count_o); else n_pass++;
    @(posedge clk); #1;
    wait_drain();
  endtask

  task automatic test_load();
    logic        exp_fv;
    logic [31:0] exp_fd;
    mem_ready_i = 1'b0;
    drive_store(32'h400, 4'b0011, 32'h0000_1234);
`ifdef WBUF_FWD_EN
    exp_fv = 1'b1; exp_fd = 32'h0000_1234;
`else
    exp_fv = 1'b0; exp_fd = 32'h0;
`endif
    ld_addr_i = 32'h400; ld_be_i = 4'b0011; #1;
    n_checks++; if (ld_hit_o !== 1'b1) $display("FAIL ld_hit_full got %b exp 1", ld_hit_o); else n_pass++;
    n_checks++; if (ld_fwd_valid_o !== exp_fv || ld_fwd_data_o !== exp_fd) $display("FAIL ld_fwd got v=%b d=%h exp v=%b d=%h", ld_fwd_valid_o, ld_fwd_data_o, exp_fv, exp_fd); else n_pass++;
    ld_be_i = 4'b0111; #1;
    n_checks++; if (ld_hit_o !== 1'b1 || ld_fwd_valid_o !== 1'b0 || ld_fwd_data_o !== 32'h0) $display("FAIL ld_partial got hit=%b v=%b d=%h exp 1/0/0", ld_hit_o, ld_fwd_valid_o, ld_fwd_data_o); else n_pass++;
    ld_be_i = 4'b1100; #1;
    n_checks++; if (ld_hit_o !== 1'b0) $display("FAIL ld_nolane got %b exp 0", ld_hit_o); else n_pass++;
    ld_addr_i = 32'h404; ld_be_i = 4'hF; #1;
    n_checks++; if (ld_hit_o !== 1'b0) $display("FAIL ld_otherword got %b exp 0", ld_hit_o); else n_pass++;
    ld_addr_i = 32'h0; ld_be_i = 4'h0;
    @(posedge clk); #1;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++)
          drive_store(32'h600 + 32'(4 * $urandom_range(0, 2)) + 32'($urandom_range(0, 3)),
                      4'($urandom_range(1, 15)), $urandom);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          mem_ready_i = 1'($urandom_range(0, 1));
        end
      end
    join
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full_order();
    test_coalesce();
    test_head_protect();
    test_full_pop();
    test_load();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
